// File: rtl/multi_counter.sv
// N-channel up/down counter with per-channel limit, wrap/saturate mode and a terminal-count pulse.
// Optional shared tick prescaler is compiled in when MULTI_COUNTER_PRESCALER_EN is defined.
module multi_counter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ena,
    input  logic [1:0]                          cmd,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ch_sel,
    input  logic [WIDTH-1:0]                    wr_data,
    input  logic [N-1:0]                        cnt_en,
    input  logic [N-1:0]                        dir,
    input  logic [N-1:0]                        sat,
    input  logic [PRE_W-1:0]                    presc_div,
    output logic [N*WIDTH-1:0]                  count,
    output logic [N-1:0]                        tc
);

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_LD_CNT = 2'b01;
    localparam logic [1:0] CMD_LD_LIM = 2'b10;
    localparam logic [1:0] CMD_CLR    = 2'b11;

    logic w_tick;

`ifdef MULTI_COUNTER_PRESCALER_EN
    logic [PRE_W-1:0] r_presc;

    // The prescaler only advances while ena is high, so ena low freezes tick phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (ena) begin
            if (r_presc == presc_div) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign w_tick = ena && (r_presc == presc_div);
`else
    logic w_unused_presc;
    assign w_unused_presc = ^presc_div;
    assign w_tick         = ena;
`endif

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [WIDTH-1:0] r_count;
        logic [WIDTH-1:0] r_limit;
        logic             r_tc;
        logic             w_hit;
        logic             w_bound;
        logic             w_step;
        logic [WIDTH-1:0] w_next;

        // ch_sel values at or beyond N can never match a channel, so such commands are dropped.
        assign w_hit   = (cmd != CMD_NOP) && (int'(ch_sel) == g);
        assign w_bound = dir[g] ? (r_count >= r_limit) : (r_count == '0);
        assign w_step  = w_tick && cnt_en[g] && !w_hit;

        always_comb begin
            w_next = r_count;
            if (!w_bound) begin
                w_next = dir[g] ? (r_count + 1'b1) : (r_count - 1'b1);
            end else if (!sat[g]) begin
                w_next = dir[g] ? '0 : r_limit;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_count <= '0;
                r_limit <= '1;
                r_tc    <= 1'b0;
            end else begin
                r_tc <= w_step && w_bound;
                if (w_hit) begin
                    case (cmd)
                        CMD_LD_CNT: r_count <= wr_data;
                        CMD_LD_LIM: r_limit <= wr_data;
                        CMD_CLR:    r_count <= '0;
                        default:    ;
                    endcase
                end else if (w_step) begin
                    r_count <= w_next;
                end
            end
        end

        assign count[g*WIDTH +: WIDTH] = r_count;
        assign tc[g]                   = r_tc;
    end

endmodule

// File: tb/tb_multi_counter.sv
// Bench for multi_counter (N=4, WIDTH=8): vector table, directed corner sequences, random run vs. model.
// Prescaler sequence is included when MULTI_COUNTER_PRESCALER_EN is defined.
module tb_multi_counter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int PRE_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ena = 1'b0;
    logic [1:0]         cmd = 2'b00;
    logic [1:0]         ch_sel = 2'd0;
    logic [WIDTH-1:0]   wr_data = '0;
    logic [N-1:0]       cnt_en = '0;
    logic [N-1:0]       dir = '0;
    logic [N-1:0]       sat = '0;
    logic [PRE_W-1:0]   presc_div = '0;
    logic [N*WIDTH-1:0] count;
    logic [N-1:0]       tc;

    int n_checks = 0;
    int n_fail   = 0;

    multi_counter #(.N(N), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .cmd(cmd), .ch_sel(ch_sel),
        .wr_data(wr_data), .cnt_en(cnt_en), .dir(dir), .sat(sat),
        .presc_div(presc_div), .count(count), .tc(tc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain integer arithmetic on the counting rules.
    int m_cnt [N];
    int m_lim [N];
    int m_presc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_lim[i] = (1 << WIDTH) - 1;
        end
        m_presc = 0;
    endtask

    logic [N-1:0] m_tc;

    task automatic model_step();
        bit tick;
        tick = 1'b0;
        if (ena) begin
`ifdef MULTI_COUNTER_PRESCALER_EN
            tick    = (m_presc == int'(presc_div));
            m_presc = tick ? 0 : (m_presc + 1) % (1 << PRE_W);
`else
            tick = 1'b1;
`endif
        end
        for (int i = 0; i < N; i++) begin
            bit hit;
            bit stepping;
            bit at_b;
            hit      = (cmd != 2'b00) && (int'(ch_sel) == i);
            stepping = tick && cnt_en[i] && !hit;
            at_b     = dir[i] ? (m_cnt[i] >= m_lim[i]) : (m_cnt[i] == 0);
            m_tc[i]  = stepping && at_b;
            if (hit) begin
                case (cmd)
                    2'b01:   m_cnt[i] = int'(wr_data);
                    2'b10:   m_lim[i] = int'(wr_data);
                    2'b11:   m_cnt[i] = 0;
                    default: ;
                endcase
            end else if (stepping) begin
                if (!at_b) m_cnt[i] = (m_cnt[i] + (dir[i] ? 1 : -1) + (1 << WIDTH)) % (1 << WIDTH);
                else if (!sat[i]) m_cnt[i] = dir[i] ? 0 : m_lim[i];
            end
        end
    endtask

    function automatic logic [N*WIDTH-1:0] model_count();
        logic [N*WIDTH-1:0] r;
        for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = m_cnt[i][WIDTH-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance the model, sample at next posedge+1.
    task automatic apply(input logic e, input logic [1:0] c, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] ce, input logic [3:0] dr, input logic [3:0] st);
        ena = e; cmd = c; ch_sel = s; wr_data = d; cnt_en = ce; dir = dr; sat = st;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0; cmd = 2'b00; cnt_en = '0;
        model_reset();
        m_tc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ena;
        logic [1:0]  cmd;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  cen;
        logic [3:0]  dir;
        logic [3:0]  sat;
        logic [31:0] exp_cnt;
        logic [3:0]  exp_tc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{1'b1, 2'b01, 2'd0, 8'h10, 4'b0000, 4'b0000, 4'b0000, 32'h00000010, 4'b0000};
        tbl[1]  = '{1'b1, 2'b10, 2'd1, 8'h03, 4'b0000, 4'b0000, 4'b0000, 32'h00000010, 4'b0000};
        tbl[2]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b1111, 4'b0000, 32'h01010111, 4'b0000};
        tbl[3]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b1111, 4'b0000, 32'h02020212, 4'b0000};
        tbl[4]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b1111, 4'b0000, 32'h03030313, 4'b0000};
        tbl[5]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b1111, 4'b0000, 32'h04040014, 4'b0010};
        tbl[6]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b0000, 4'b1111, 32'h03030013, 4'b0010};
        tbl[7]  = '{1'b0, 2'b11, 2'd2, 8'h00, 4'b1111, 4'b0000, 4'b1111, 32'h03000013, 4'b0000};
        tbl[8]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b0100, 4'b0000, 4'b0000, 32'h03FF0013, 4'b0100};
        tbl[9]  = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b0100, 4'b0100, 4'b0100, 32'h03FF0013, 4'b0100};
        tbl[10] = '{1'b1, 2'b10, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000, 32'h03FF0013, 4'b0000};
        tbl[11] = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000, 32'h03FF0000, 4'b0001};
        tbl[12] = '{1'b1, 2'b00, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000, 32'h03FF0000, 4'b0001};
        tbl[13] = '{1'b0, 2'b00, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000, 32'h03FF0000, 4'b0000};
        tbl[14] = '{1'b1, 2'b01, 2'd0, 8'hAB, 4'b1001, 4'b1001, 4'b0000, 32'h04FF00AB, 4'b0000};

        // Reset state
        do_reset();
        check("reset_count", count, 32'h0);
        check("reset_tc", {28'b0, tc}, 32'h0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].ena, tbl[i].cmd, tbl[i].sel, tbl[i].data, tbl[i].cen, tbl[i].dir, tbl[i].sat);
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_tc", i), {28'b0, tc}, {28'b0, tbl[i].exp_tc});
        end

        // ch0 up/wrap from reset: wraps on tick 256 with a single tc pulse
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000);
            check($sformatf("wrap_count_k%0d", k), count, 32'(k % 256));
            check($sformatf("wrap_tc_k%0d", k), {28'b0, tc}, (k == 256) ? 32'h1 : 32'h0);
        end

        // ch2 saturating at limit 5
        do_reset();
        apply(1'b1, 2'b10, 2'd2, 8'd5, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 1; k <= 10; k++) begin
            apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b0100, 4'b0100, 4'b0100);
            check($sformatf("sat_count_k%0d", k), count, 32'((k < 5 ? k : 5)) << 16);
            check($sformatf("sat_tc_k%0d", k), {28'b0, tc}, (k >= 6) ? 32'h4 : 32'h0);
        end

        // ch3 down/wrap from 0 reloads limit
        do_reset();
        apply(1'b1, 2'b10, 2'd3, 8'd9, 4'b0000, 4'b0000, 4'b0000);
        apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b1000, 4'b0000, 4'b0000);
        check("down_wrap_count", count, 32'h09000000);
        check("down_wrap_tc", {28'b0, tc}, 32'h8);

        // LOAD count on ch0 while every channel counts
        do_reset();
        for (int k = 0; k < 3; k++) apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b1111, 4'b0000);
        apply(1'b1, 2'b01, 2'd0, 8'h40, 4'b1111, 4'b1111, 4'b0000);
        check("load_busy_count", count, 32'h04040440);
        check("load_busy_tc", {28'b0, tc}, 32'h0);

        // Asynchronous reset mid-count with a LOAD pending on ch1
        do_reset();
        for (int k = 0; k < 5; k++) apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b1111, 4'b1111, 4'b0000);
        ena = 1'b1; cmd = 2'b01; ch_sel = 2'd1; wr_data = 8'h77;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", count, 32'h0);
        check("async_rst_tc", {28'b0, tc}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd = 2'b00;
        model_reset();
        check("post_rst_count", count, 32'h0);
        apply(1'b1, 2'b01, 2'd1, 8'hFE, 4'b0000, 4'b0000, 4'b0000);
        check("rst_lim_load", count, 32'h0000FE00);
        apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b0010, 4'b0010, 4'b0000);
        check("rst_lim_step1", count, 32'h0000FF00);
        check("rst_lim_tc1", {28'b0, tc}, 32'h0);
        apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b0010, 4'b0010, 4'b0000);
        check("rst_lim_step2", count, 32'h0);
        check("rst_lim_tc2", {28'b0, tc}, 32'h2);

`ifdef MULTI_COUNTER_PRESCALER_EN
        // Prescaler divide-by-4, then ena low freezes everything
        do_reset();
        presc_div = 8'd3;
        for (int k = 1; k <= 8; k++) begin
            apply(1'b1, 2'b00, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000);
            check($sformatf("presc_count_k%0d", k), count, 32'(k / 4));
        end
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 2'b00, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0000);
            check($sformatf("presc_hold_k%0d", k), count, 32'h2);
        end
        presc_div = 8'd0;
`endif

        // Random run against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [1:0] rc;
            logic [7:0] rd;
            rc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rd = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            apply(($urandom_range(0, 4) != 0), rc, 2'($urandom_range(0, 3)), rd,
                  4'($urandom), 4'($urandom), 4'($urandom));
            check($sformatf("rand_count_k%0d", k), count, model_count());
            check($sformatf("rand_tc_k%0d", k), {28'b0, tc}, {28'b0, m_tc});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_counter.md
MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 SHALL have parameter N, default 4: channel count, 1..8.
REQ-002 SHALL have parameter WIDTH, default 8: counter width per channel, 2..16.
REQ-003 SHALL have parameter PRE_W, default 8: prescaler divide-register width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ena  input  1  global run enable; low freezes prescaler and counting.
REQ-007 SHALL have port cmd  input  2  00 NOP, 01 LOAD count, 10 LOAD limit, 11 CLEAR count.
REQ-008 SHALL have port ch_sel  input  max(1,$clog2(N))  channel addressed by cmd.
REQ-009 SHALL have port wr_data  input  WIDTH  value for LOAD commands.
REQ-010 SHALL have port cnt_en  input  N  per-channel count enable.
REQ-011 SHALL have port dir  input  N  per-channel direction, 1 up, 0 down.
REQ-012 SHALL have port sat  input  N  per-channel mode, 1 saturate, 0 wrap.
REQ-013 SHALL have port presc_div  input  PRE_W  tick period minus one (macro builds only).
REQ-014 SHALL have port count  output  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH], registered.
REQ-015 SHALL have port tc  output  N  registered one-cycle terminal-count pulse per channel.

Function
REQ-016 SHALL generate internal tick: every cycle ena=1 (no macro), else per REQ-031.
REQ-017 SHALL step channel i on a tick cycle when cnt_en[i]=1 and channel i is not the target of a non-NOP cmd.
REQ-018 SHALL treat boundary as: up count>=limit[i]; down count==0.
REQ-019 SHALL step off-boundary: up count+1, down count-1, modulo 2^WIDTH.
REQ-020 SHALL at boundary in wrap mode: up -> 0, down -> limit[i].
REQ-021 SHALL at boundary in saturate mode hold count unchanged.
REQ-022 SHALL assert tc[i] the cycle after every stepping tick that found channel i at boundary (wrap or saturate hold), low otherwise.
REQ-023 SHALL execute cmd the same edge, irrespective of ena: LOAD count sets count[i]=wr_data, LOAD limit sets limit[i]=wr_data, CLEAR sets count[i]=0; no tc generated.
REQ-024 SHALL give cmd priority over counting on the addressed channel only; other channels step normally the same cycle.
REQ-025 SHALL ignore cmd when ch_sel>=N.
REQ-026 SHALL make count visible one edge after the tick or cmd that changes it (latency 1).
REQ-027 SHALL treat limit=0 as up-count pinned at 0 (wrap) with tc every tick.

Reset
REQ-028 SHALL on rst=1, asynchronously: all count 0, all limit 2^WIDTH-1, tc 0, prescaler count 0.
REQ-029 SHALL abandon any in-progress command or step on reset; first step requires a tick after rst deasserts.

Configuration
REQ-030 SHALL compile the prescaler only when macro MULTI_COUNTER_PRESCALER_EN is defined.
REQ-031 SHALL with macro: PRE_W-bit counter advances when ena=1; tick when it equals presc_div, then returns 0; presc_div=0 gives a tick every ena cycle; ena=0 holds it.
REQ-032 SHALL without macro: no prescaler state, presc_div present but ignored, tick=ena.

Verification
REQ-033 SHALL verify: N=4, WIDTH=8, reset, ch0 up wrap, cnt_en=0001, ena=1, 260 cycles -> count0 wraps 255->0 at cycle 256, tc[0] single pulse next cycle, ch1..3 stay 0.
REQ-034 SHALL verify: LOAD limit ch2=5, ch2 up sat enabled 10 ticks -> count2 holds 5 from tick 5, tc[2] pulses on ticks 6..10.
REQ-035 SHALL verify: ch3 down wrap, LOAD limit=9, count 0, one tick -> count3=9, tc[3]=1 next cycle.
REQ-036 SHALL verify: LOAD count ch0=0x40 while all channels counting -> count0=0x40 next edge, ch1 advanced by 1, no tc.
REQ-037 SHALL verify: with macro, presc_div=3, ch0 up -> count0 advances every 4th cycle; ena low 5 cycles -> no change.
REQ-038 SHALL verify: rst pulse mid-count with ch_sel=1 LOAD pending -> counts 0, limits 0xFF, tc 0 immediately, no load applied.
